// File: rtl/overlay_pixel_mixer_if.sv
// Show-ahead overlay FIFO port: head-of-queue pixel, empty flag and pop strobe.
interface overlay_pixel_mixer_if #(
  parameter int pixelWidth = 24
);
  logic [pixelWidth-1:0] fifoData;
  logic                  fifoEmpty;
  logic                  fifoRead;

  modport master (input fifoData, input fifoEmpty, output fifoRead);
  modport slave  (output fifoData, output fifoEmpty, input fifoRead);
endinterface

// File: rtl/overlay_pixel_mixer.sv
// Overlay window mixer between the HDMI timing counters and the transmitter;
// replaces background with FIFO pixels inside a per-frame latched window.
module overlay_pixel_mixer #(
  parameter int hBusWidth  = 12,
  parameter int vBusWidth  = 12,
  parameter int pixelWidth = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [hBusWidth-1:0]  hCount,
  input  logic [vBusWidth-1:0]  vCount,
  input  logic                  deIn,
  input  logic                  hsyncIn,
  input  logic                  vsyncIn,
  input  logic [pixelWidth-1:0] bgRgb,
  input  logic                  ovlEnable,
  input  logic [hBusWidth-1:0]  ovlX,
  input  logic [vBusWidth-1:0]  ovlY,
  input  logic [hBusWidth-1:0]  ovlW,
  input  logic [vBusWidth-1:0]  ovlH,
  input  logic                  keyEnable,
  input  logic [pixelWidth-1:0] keyColour,
  overlay_pixel_mixer_if.master fifo,
  output logic                  frameSync,
  output logic                  underflow,
  output logic [pixelWidth-1:0] rgbOut,
  output logic                  deOut,
  output logic                  hsyncOut,
  output logic                  vsyncOut
);

  typedef enum logic [1:0] {WAIT_FRAME, ACTIVE, STALLED} state_t;

  state_t                state, state_next;
  logic                  vsync_prev, vsync_edge;
  logic                  lat_enable, lat_key_enable;
  logic [hBusWidth-1:0]  lat_x, lat_w;
  logic [vBusWidth-1:0]  lat_y, lat_h;
  logic [pixelWidth-1:0] lat_key;
  logic [hBusWidth:0]    h_end;
  logic [vBusWidth:0]    v_end;
  logic                  in_window, fifo_read, stall;
  logic [pixelWidth-1:0] pixel_sel;
  logic [pixelWidth-1:0] s1_rgb;
  logic                  s1_de, s1_hs, s1_vs;

  assign vsync_edge = vsyncIn & ~vsync_prev;

  // One extra bit on the window end keeps X+W from wrapping past the raster.
  always_comb begin
    h_end     = {1'b0, lat_x} + {1'b0, lat_w};
    v_end     = {1'b0, lat_y} + {1'b0, lat_h};
    in_window = deIn & lat_enable
              & (hCount >= lat_x) & ({1'b0, hCount} < h_end)
              & (vCount >= lat_y) & ({1'b0, vCount} < v_end);
  end

  always_comb begin
    state_next = state;
    fifo_read  = 1'b0;
    stall      = 1'b0;
    case (state)
      ACTIVE: begin
        fifo_read = in_window & ~fifo.fifoEmpty;
        stall     = in_window & fifo.fifoEmpty;
        if (stall) state_next = STALLED;
      end
      default: ;
    endcase
    if (vsync_edge) state_next = ACTIVE;
  end

  assign fifo.fifoRead = fifo_read;

  // Key-coloured words are still popped but show the background.
  always_comb begin
    pixel_sel = bgRgb;
    if (!deIn)
      pixel_sel = '0;
    else if (fifo_read && !(lat_key_enable && (fifo.fifoData == lat_key)))
      pixel_sel = fifo.fifoData;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= WAIT_FRAME;
      vsync_prev     <= 1'b1;
      frameSync      <= 1'b0;
      underflow      <= 1'b0;
      lat_enable     <= 1'b0;
      lat_key_enable <= 1'b0;
      lat_x          <= '0;
      lat_y          <= '0;
      lat_w          <= '0;
      lat_h          <= '0;
      lat_key        <= '0;
    end else begin
      state      <= state_next;
      vsync_prev <= vsyncIn;
      frameSync  <= vsync_edge;
      if (stall) underflow <= 1'b1;
      if (vsync_edge) begin
        lat_enable     <= ovlEnable;
        lat_key_enable <= keyEnable;
        lat_x          <= ovlX;
        lat_y          <= ovlY;
        lat_w          <= ovlW;
        lat_h          <= ovlH;
        lat_key        <= keyColour;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_rgb   <= '0;
      s1_de    <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      rgbOut   <= '0;
      deOut    <= 1'b0;
      hsyncOut <= 1'b0;
      vsyncOut <= 1'b0;
    end else begin
      s1_rgb   <= pixel_sel;
      s1_de    <= deIn;
      s1_hs    <= hsyncIn;
      s1_vs    <= vsyncIn;
      rgbOut   <= s1_rgb;
      deOut    <= s1_de;
      hsyncOut <= s1_hs;
      vsyncOut <= s1_vs;
    end
  end

endmodule

// File: tb/tb_overlay_pixel_mixer.sv
// Directed bench for overlay_pixel_mixer: sparse raster scans around the window
// with a queue-backed show-ahead FIFO and a 2-cycle expected-output history.
module tb_overlay_pixel_mixer;

  logic        clock, reset;
  logic [11:0] hCount, vCount, ovlX, ovlW;
  logic [11:0] ovlY, ovlH;
  logic        deIn, hsyncIn, vsyncIn, ovlEnable, keyEnable;
  logic [23:0] bgRgb, keyColour, rgbOut;
  logic        frameSync, underflow, deOut, hsyncOut, vsyncOut;

  overlay_pixel_mixer_if #(.pixelWidth(24)) fifo_if ();

  overlay_pixel_mixer #(.hBusWidth(12), .vBusWidth(12), .pixelWidth(24)) dut (
    .clock(clock), .reset(reset), .hCount(hCount), .vCount(vCount),
    .deIn(deIn), .hsyncIn(hsyncIn), .vsyncIn(vsyncIn), .bgRgb(bgRgb),
    .ovlEnable(ovlEnable), .ovlX(ovlX), .ovlY(ovlY), .ovlW(ovlW), .ovlH(ovlH),
    .keyEnable(keyEnable), .keyColour(keyColour), .fifo(fifo_if),
    .frameSync(frameSync), .underflow(underflow), .rgbOut(rgbOut),
    .deOut(deOut), .hsyncOut(hsyncOut), .vsyncOut(vsyncOut)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int          checks = 0, failures = 0;
  logic [23:0] fq[$];
  int          m_state;
  logic        m_vs_prev, m_fs, m_uf;
  logic        l_en, l_key_en;
  int          l_x, l_y, l_w, l_h;
  logic [23:0] l_key;
  logic [23:0] e_rgb[2];
  logic        e_de[2], e_hs[2], e_vs[2];
  int          rd_count, fs_count, first_rd_h, first_rd_v, last_rd_h, last_rd_v;

  task automatic model_reset();
    m_state = 0; m_vs_prev = 1'b1; m_fs = 1'b0; m_uf = 1'b0;
    l_en = 1'b0; l_key_en = 1'b0; l_x = 0; l_y = 0; l_w = 0; l_h = 0; l_key = '0;
    for (int i = 0; i < 2; i++) begin
      e_rgb[i] = '0; e_de[i] = 1'b0; e_hs[i] = 1'b0; e_vs[i] = 1'b0;
    end
  endtask

  task automatic tick(input int h, input int v, input logic de, input logic hs, input logic vs);
    logic [23:0] bg, exp_pix;
    logic        empty, in_win, edge_now, exp_rd, obs_rd;
    hs = hs;
    bg = {v[7:0], h[7:0], 8'h3C};
    @(negedge clock);
    hCount = h[11:0]; vCount = v[11:0]; deIn = de; hsyncIn = hs; vsyncIn = vs; bgRgb = bg;
    empty = (fq.size() == 0);
    fifo_if.fifoEmpty = empty;
    fifo_if.fifoData  = empty ? 24'hBAD0BA : fq[0];
    #1;
    in_win   = de && l_en && h >= l_x && h < l_x + l_w && v >= l_y && v < l_y + l_h;
    edge_now = vs && !m_vs_prev;
    exp_rd   = (m_state == 1) && in_win && !empty;
    if (!de) exp_pix = '0;
    else if (exp_rd && !(l_key_en && fq[0] == l_key)) exp_pix = fq[0];
    else exp_pix = bg;
    obs_rd = fifo_if.fifoRead;

    checks += 7;
    if (obs_rd !== exp_rd) begin
      failures++; $display("FAIL fifoRead h=%0d v=%0d got=%b exp=%b", h, v, obs_rd, exp_rd);
    end
    if (frameSync !== m_fs) begin
      failures++; $display("FAIL frameSync h=%0d v=%0d got=%b exp=%b", h, v, frameSync, m_fs);
    end
    if (underflow !== m_uf) begin
      failures++; $display("FAIL underflow h=%0d v=%0d got=%b exp=%b", h, v, underflow, m_uf);
    end
    if (rgbOut !== e_rgb[1]) begin
      failures++; $display("FAIL rgbOut h=%0d v=%0d got=%h exp=%h", h, v, rgbOut, e_rgb[1]);
    end
    if (deOut !== e_de[1]) begin
      failures++; $display("FAIL deOut h=%0d v=%0d got=%b exp=%b", h, v, deOut, e_de[1]);
    end
    if (hsyncOut !== e_hs[1]) begin
      failures++; $display("FAIL hsyncOut h=%0d v=%0d got=%b exp=%b", h, v, hsyncOut, e_hs[1]);
    end
    if (vsyncOut !== e_vs[1]) begin
      failures++; $display("FAIL vsyncOut h=%0d v=%0d got=%b exp=%b", h, v, vsyncOut, e_vs[1]);
    end
    if (frameSync === 1'b1) fs_count++;
    if (obs_rd === 1'b1) begin
      if (rd_count == 0) begin first_rd_h = h; first_rd_v = v; end
      last_rd_h = h; last_rd_v = v;
      rd_count++;
    end

    m_fs = edge_now;
    if (m_state == 1 && in_win && empty) begin m_uf = 1'b1; m_state = 2; end
    if (edge_now) begin
      m_state = 1; l_en = ovlEnable; l_key_en = keyEnable; l_key = keyColour;
      l_x = int'(ovlX); l_y = int'(ovlY); l_w = int'(ovlW); l_h = int'(ovlH);
    end
    m_vs_prev = vs;
    e_rgb[1] = e_rgb[0]; e_de[1] = e_de[0]; e_hs[1] = e_hs[0]; e_vs[1] = e_vs[0];
    e_rgb[0] = exp_pix;  e_de[0] = de;      e_hs[0] = hs;      e_vs[0] = vs;

    @(posedge clock);
    if (obs_rd === 1'b1 && fq.size() > 0) void'(fq.pop_front());
  endtask

  // Asserts reset with the given raster inputs and checks outputs clear at once.
  task automatic do_reset(input int h, input int v, input logic de, input logic vs_rel);
    @(negedge clock);
    hCount = h[11:0]; vCount = v[11:0]; deIn = de; vsyncIn = vs_rel; reset = 1'b1;
    #1;
    checks += 7;
    if (rgbOut !== '0)       begin failures++; $display("FAIL reset_rgbOut got=%h exp=0", rgbOut); end
    if (deOut !== 1'b0)      begin failures++; $display("FAIL reset_deOut got=%b exp=0", deOut); end
    if (hsyncOut !== 1'b0)   begin failures++; $display("FAIL reset_hsyncOut got=%b exp=0", hsyncOut); end
    if (vsyncOut !== 1'b0)   begin failures++; $display("FAIL reset_vsyncOut got=%b exp=0", vsyncOut); end
    if (frameSync !== 1'b0)  begin failures++; $display("FAIL reset_frameSync got=%b exp=0", frameSync); end
    if (underflow !== 1'b0)  begin failures++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
    if (fifo_if.fifoRead !== 1'b0) begin
      failures++; $display("FAIL reset_fifoRead got=%b exp=0", fifo_if.fifoRead);
    end
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic set_window(input logic en, input int x, input int y, input int w, input int hh,
                            input logic ke, input logic [23:0] kc);
    ovlEnable = en; ovlX = x[11:0]; ovlY = y[11:0]; ovlW = w[11:0]; ovlH = hh[11:0];
    keyEnable = ke; keyColour = kc;
  endtask

  task automatic preload(input int n, input logic key3);
    fq.delete();
    for (int i = 1; i <= n; i++) fq.push_back((key3 && i == 3) ? 24'h00FF00 : 24'(i));
  endtask

  task automatic frame_start();
    repeat (2) tick(1300, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick(1300, 0, 1'b0, 1'b0, 1'b1);
    repeat (2) tick(1300, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic scan_line(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) tick(h, v, 1'b1, 1'b0, 1'b0);
    repeat (2) tick(1290, v, 1'b0, 1'b1, 1'b0);
    repeat (2) tick(1295, v, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin failures++; $display("FAIL %s got=%0d exp=%0d", name, got, exp); end
  endtask

  task automatic test_reset();
    do_reset(0, 0, 1'b0, 1'b0);
    repeat (3) tick(10, 10, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_window();
    set_window(1'b1, 100, 50, 4, 2, 1'b0, 24'h0);
    preload(8, 1'b0);
    frame_start();
    rd_count = 0;
    set_window(1'b1, 0, 0, 200, 200, 1'b0, 24'h0);
    for (int v = 49; v <= 52; v++) scan_line(v, 96, 107);
    expect_int("window_reads", rd_count, 8);
    checks++;
    if (first_rd_h != 100 || first_rd_v != 50 || last_rd_h != 103 || last_rd_v != 51) begin
      failures++;
      $display("FAIL window_pos got=(%0d,%0d)..(%0d,%0d) exp=(100,50)..(103,51)",
               first_rd_h, first_rd_v, last_rd_h, last_rd_v);
    end
    expect_int("window_fifo_left", fq.size(), 0);
  endtask

  task automatic test_key();
    set_window(1'b1, 100, 50, 4, 2, 1'b1, 24'h00FF00);
    preload(8, 1'b1);
    frame_start();
    rd_count = 0;
    for (int v = 49; v <= 52; v++) scan_line(v, 96, 107);
    expect_int("key_reads", rd_count, 8);
  endtask

  task automatic test_underflow();
    set_window(1'b1, 100, 50, 4, 2, 1'b0, 24'h0);
    preload(5, 1'b0);
    frame_start();
    rd_count = 0;
    scan_line(49, 96, 107);
    scan_line(50, 96, 107);
    for (int h = 96; h <= 101; h++) tick(h, 51, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) fq.push_back(24'hABC000 + 24'(i));
    scan_line(51, 102, 107);
    scan_line(52, 96, 107);
    expect_int("underflow_reads", rd_count, 5);
    expect_int("underflow_flag", int'(underflow), 1);
    expect_int("underflow_no_reads_after", fq.size(), 3);
    preload(8, 1'b0);
    fs_count = 0;
    frame_start();
    expect_int("underflow_framesync_pulses", fs_count, 1);
    rd_count = 0;
    for (int v = 49; v <= 52; v++) scan_line(v, 96, 107);
    expect_int("underflow_resume_reads", rd_count, 8);
    expect_int("underflow_sticky", int'(underflow), 1);
  endtask

  task automatic test_clip();
    set_window(1'b1, 1278, 719, 8, 8, 1'b0, 24'h0);
    preload(8, 1'b0);
    frame_start();
    rd_count = 0;
    scan_line(718, 1272, 1279);
    scan_line(719, 1272, 1279);
    expect_int("clip_reads", rd_count, 2);
    set_window(1'b1, 100, 50, 0, 2, 1'b0, 24'h0);
    preload(8, 1'b0);
    frame_start();
    rd_count = 0;
    for (int v = 49; v <= 52; v++) scan_line(v, 96, 107);
    expect_int("zero_width_reads", rd_count, 0);
  endtask

  task automatic test_midframe_reset();
    set_window(1'b1, 100, 50, 4, 2, 1'b0, 24'h0);
    preload(8, 1'b0);
    frame_start();
    rd_count = 0;
    for (int h = 96; h <= 101; h++) tick(h, 50, 1'b1, 1'b0, 1'b0);
    expect_int("pre_reset_reads", rd_count, 2);
    do_reset(102, 50, 1'b1, 1'b1);
    fs_count = 0;
    rd_count = 0;
    repeat (3) tick(1300, 0, 1'b0, 1'b0, 1'b1);
    repeat (2) tick(1300, 0, 1'b0, 1'b0, 1'b0);
    scan_line(50, 96, 107);
    expect_int("post_reset_framesync", fs_count, 0);
    expect_int("post_reset_reads", rd_count, 0);
    frame_start();
    scan_line(50, 96, 107);
    expect_int("post_reset_resume_reads", rd_count, 4);
  endtask

  task automatic test_alignment();
    set_window(1'b0, 0, 0, 1280, 720, 1'b0, 24'h0);
    frame_start();
    for (int i = 0; i < 80; i++)
      tick($urandom_range(0, 1400), $urandom_range(0, 800),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (3) tick(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    hCount = '0; vCount = '0; deIn = 1'b0; hsyncIn = 1'b0; vsyncIn = 1'b0; bgRgb = '0;
    set_window(1'b0, 0, 0, 0, 0, 1'b0, 24'h0);
    fifo_if.fifoData = '0; fifo_if.fifoEmpty = 1'b1;
    rd_count = 0; fs_count = 0;
    first_rd_h = -1; first_rd_v = -1; last_rd_h = -1; last_rd_v = -1;
    model_reset();
    test_reset();
    test_window();
    test_key();
    test_underflow();
    test_clip();
    test_midframe_reset();
    test_alignment();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/overlay_pixel_mixer.md
Name: overlay_pixel_mixer

Overview:
- Stage directly downstream of the HDMI timing counters (hCount/vCount, DE, HSYNC, VSYNC).
- Consumes the raster position and a show-ahead FIFO of 24-bit overlay pixels streamed from DDR.
- Substitutes overlay pixels inside a rectangular window and passes the background everywhere else.
- Delays syncs and DE to match its pipeline, so the HDMI transmitter sees aligned RGB, DE, HSYNC and VSYNC.

Parameters:
- hBusWidth, 12, horizontal coordinate width.
- vBusWidth, 12, vertical coordinate width.
- pixelWidth, 24, RGB pixel width (8:8:8).

Ports:
- clock, input, 1, pixel clock.
- reset, input, 1, asynchronous active-high reset.
- hCount, input, hBusWidth, current horizontal pixel position.
- vCount, input, vBusWidth, current vertical pixel position.
- deIn, input, 1, data enable from the timing counters.
- hsyncIn, input, 1, horizontal sync from the timing counters.
- vsyncIn, input, 1, vertical sync from the timing counters.
- bgRgb, input, pixelWidth, background pixel for the current position.
- ovlEnable, input, 1, overlay enable (slide switch).
- ovlX, input, hBusWidth, window left edge.
- ovlY, input, vBusWidth, window top edge.
- ovlW, input, hBusWidth, window width.
- ovlH, input, vBusWidth, window height.
- keyEnable, input, 1, colour-key transparency enable.
- keyColour, input, pixelWidth, transparent colour.
- fifoData, input, pixelWidth, head-of-FIFO pixel; valid while fifoEmpty is 0.
- fifoEmpty, input, 1, FIFO empty flag.
- fifoRead, output, 1, pop strobe; combinational.
- frameSync, output, 1, one-cycle pulse telling the DDR reader to flush and restart at image origin.
- underflow, output, 1, sticky flag: FIFO was empty inside the active window.
- rgbOut, output, pixelWidth, mixed pixel.
- deOut, output, 1, delayed data enable.
- hsyncOut, output, 1, delayed horizontal sync.
- vsyncOut, output, 1, delayed vertical sync.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - rgbOut, deOut, hsyncOut, vsyncOut, frameSync and underflow are 0.
  - The FSM is in WAIT_FRAME.
  - The latched window registers are 0.
  - vsyncPrev is 1, which suppresses a false edge at reset release.
- Reset asserted mid-frame: outputs go to 0 immediately. After release, no FIFO reads occur until the next vsyncIn rising edge.
- Frame edge: vsyncEdge = vsyncIn & ~vsyncPrev.
- On vsyncEdge, in every state:
  - Latch ovlEnable, ovlX, ovlY, ovlW, ovlH, keyEnable and keyColour.
  - Register frameSync = 1 for exactly one cycle (high on the cycle after the edge).
  - Next state is ACTIVE.
- Window changes on the inputs mid-frame have no effect until the next vsyncEdge.
- inWindow = deIn & latched enable & hCount >= X & hCount < X+W & vCount >= Y & vCount < Y+H.
  - Sums use hBusWidth+1 / vBusWidth+1 bits, so no wrap-around.
  - W = 0 or H = 0 gives an empty window.
  - The window clips naturally at the raster edge.
- FSM states:
  - WAIT_FRAME: no reads; output is background.
  - ACTIVE: fifoRead = inWindow & ~fifoEmpty. If inWindow & fifoEmpty, set underflow and go to STALLED.
  - STALLED: no reads; background output for the rest of the frame. Leave only on vsyncEdge (to ACTIVE).
- Pipeline latency is exactly 2 cycles for rgbOut, deOut, hsyncOut and vsyncOut.
  - Stage 1 registers the selected pixel and the sync/DE bits.
  - Stage 2 registers the outputs.
- Pixel select in stage 1, in priority order:
  - ~deIn: 0.
  - fifoRead & keyEnable & fifoData == keyColour: bgRgb. The pixel is still consumed.
  - fifoRead: fifoData.
  - Otherwise: bgRgb.
- Sync polarity passes through unchanged.
- Reads per frame with no underflow = W_clipped × H_clipped.
- underflow clears only on reset.
- fifoEmpty deasserting in the same cycle as the stall transition does not cancel the stall.

Test Plan:
- Window (100,50,4,2), FIFO preloaded with 0x000001..0x000008, 1280x720 raster → after vsyncEdge:
  - exactly 8 fifoRead pulses, at hCount 100..103 on vCount 50 and 51.
  - rgbOut shows the values in order 2 cycles later.
  - everywhere else rgbOut = bgRgb when DE is high and 0 when DE is low.
- Key test: keyEnable=1, keyColour=0x00FF00, FIFO word 3 = 0x00FF00 → that position shows bgRgb; the read count is still 8.
- Underflow: only 5 words in FIFO → underflow sets at the 6th window pixel; no further reads that frame. On the next vsyncEdge, frameSync pulses for 1 cycle and reads resume.
- Clipping and empty windows: window (1278,719,8,8) → exactly 2 reads per frame. W=0 → 0 reads.
- Reset asserted at pixel (102,50):
  - all outputs 0 within the same cycle.
  - after release, no reads until a vsyncIn rising edge.
  - vsyncIn high at release causes no frameSync.
- Alignment: toggle hsyncIn/vsyncIn/deIn with random patterns → the outputs equal the inputs delayed by exactly 2 cycles.
